// File: rtl/clk_gate_pkg.sv
// Shared types and limits for the clock-gating controller.
package clk_gate_pkg;

    // Controller state; encodings are visible on state_o.
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_IDLE_WAIT = 2'd1,
        ST_GATED     = 2'd2,
        ST_WAKE      = 2'd3
    } clk_gate_state_e;

    // Largest legal WAKE_CYCLES; it sizes the wake counter.
    localparam int CLK_GATE_WAKE_MAX = 15;

endpackage : clk_gate_pkg

// File: rtl/clk_gate_ctrl_icg.sv
// Behavioural integrated clock-gating cell. The enable is captured by a
// latch that is transparent while clk_i is low and holds while clk_i is high.
// The enable can therefore only change while the clock is low, so clk_o
// cannot produce a runt pulse.
module pulp_clock_gating2 (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic en_latch;

    // Enable latch, transparent during the low phase of clk_i.
    always_latch begin
        if (!clk_i) begin
            en_latch = en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_latch;

endmodule : pulp_clock_gating2

// File: rtl/clk_gate_ctrl.sv
// Clock-gating controller for a single downstream domain.
//
// The controller watches downstream idleness. After a programmable number
// of idle cycles, or on a software request, it gates the domain clock.
// Any sign of pending work wakes the clock again. ready_o reports when the
// clock has been running for WAKE_CYCLES root cycles.
//
// Software handshake (4-phase): sw_gate_req_i rises, then sw_gate_ack_o
// rises once the domain is gated. The request falls, and the ack falls on
// the following edge. If a wake cause ends the gated period while the
// request is still high, the ack drops. It rises again only when the
// controller re-enters GATED.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_CNT_W  = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int COUNT_W     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  test_en_i,
    input  logic                  auto_en_i,
    input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
    input  logic                  busy_i,
    input  logic                  wake_req_i,
    input  logic                  sw_gate_req_i,
    output logic                  sw_gate_ack_o,
    output logic                  clk_o,
    output logic                  clk_en_o,
    output logic                  ready_o,
    output logic [1:0]            state_o,
    output logic [COUNT_W-1:0]    gated_cycles_o
);

    localparam int WAKE_W = $clog2(CLK_GATE_WAKE_MAX + 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    clk_gate_state_e       state, state_nxt;
    logic [IDLE_CNT_W-1:0] idle_cnt, idle_cnt_nxt;
    logic [WAKE_W-1:0]     wake_cnt, wake_cnt_nxt;
    logic [COUNT_W-1:0]    gated_cnt;
    logic                  gate_cond;
    logic                  wake_cause;

    // Busy or pending work always blocks gating, including against a
    // software request.
    assign gate_cond  = ~busy_i & ~wake_req_i & (auto_en_i | sw_gate_req_i);
    assign wake_cause = wake_req_i | busy_i | (~auto_en_i & ~sw_gate_req_i);

    // Next-state and counter-update logic.
    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = idle_cnt;
        wake_cnt_nxt = wake_cnt;
        unique case (state)
            ST_RUN: begin
                if (gate_cond) begin
                    state_nxt    = ST_IDLE_WAIT;
                    idle_cnt_nxt = '0;
                end
            end
            ST_IDLE_WAIT: begin
                // Losing the gate condition has priority over both exits.
                // The threshold compare fires before idle_cnt can wrap.
                if (!gate_cond) begin
                    state_nxt = ST_RUN;
                end else if (sw_gate_req_i || (idle_cnt == idle_thresh_i)) begin
                    state_nxt = ST_GATED;
                end else begin
                    idle_cnt_nxt = idle_cnt + 1'b1;
                end
            end
            ST_GATED: begin
                if (wake_cause) begin
                    state_nxt    = ST_WAKE;
                    wake_cnt_nxt = '0;
                end
            end
            ST_WAKE: begin
                // Gate requests are ignored here; they are honoured once in RUN.
                wake_cnt_nxt = wake_cnt + 1'b1;
                if (wake_cnt == WAKE_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_WAKE;
            end
        endcase
    end

    // State, counters and registered outputs. Reset leaves the clock
    // running in WAKE, so the domain restarts exactly as it does on a wake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_WAKE;
            idle_cnt      <= '0;
            wake_cnt      <= '0;
            clk_en_o      <= 1'b1;
            ready_o       <= 1'b0;
            sw_gate_ack_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            idle_cnt      <= idle_cnt_nxt;
            wake_cnt      <= wake_cnt_nxt;
            clk_en_o      <= (state_nxt != ST_GATED);
            ready_o       <= (state_nxt == ST_RUN) || (state_nxt == ST_IDLE_WAIT);
            sw_gate_ack_o <= (state_nxt == ST_GATED) && sw_gate_req_i;
        end
    end

    // Saturating count of root cycles spent in GATED.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gated_cnt <= '0;
        end else if ((state == ST_GATED) && (gated_cnt != '1)) begin
            gated_cnt <= gated_cnt + 1'b1;
        end
    end

    assign state_o        = state;
    assign gated_cycles_o = gated_cnt;

    // test_en_i forces the gated clock on without affecting the FSM.
    pulp_clock_gating2 u_icg (
        .clk_i     (clk_i),
        .en_i      (clk_en_o),
        .test_en_i (test_en_i),
        .clk_o     (clk_o)
    );

endmodule : clk_gate_ctrl

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Automatic and software-requested clock-gating controller for one downstream clock domain.
- Runs on the free-running root clock and tracks downstream idleness with a hysteresis counter.
- Sequences gate/wake through an FSM and drives an ICG sub-instance that produces the gated clock.
- Sits directly upstream of the integrated clock-gating cell: it produces the registered enable the ICG consumes.

Parameters:
- IDLE_CNT_W, 8, width of idle-threshold and idle counter.
- WAKE_CYCLES, 2, root-clock cycles the gated clock runs after wake before ready_o asserts; legal range 1..15.
- COUNT_W, 16, width of the saturating gated-cycle statistic counter.

Ports:
- clk_i  in  1  free-running root clock.
- rst_i  in  1  asynchronous, active-high reset.
- test_en_i  in  1  scan/test enable; forces gated clock on.
- auto_en_i  in  1  enables automatic idle gating.
- idle_thresh_i  in  IDLE_CNT_W  idle cycles required before gating; quasi-static.
- busy_i  in  1  downstream domain activity.
- wake_req_i  in  1  upstream has pending work for the domain.
- sw_gate_req_i  in  1  software gate request, 4-phase.
- sw_gate_ack_o  out  1  software gate acknowledge.
- clk_o  out  1  gated clock to the domain.
- clk_en_o  out  1  registered enable presented to the ICG.
- ready_o  out  1  domain clock is running and stable.
- state_o  out  2  FSM state: RUN=0, IDLE_WAIT=1, GATED=2, WAKE=3.
- gated_cycles_o  out  COUNT_W  root cycles spent in GATED, saturating.

Behaviour:
- Reset (async, rst_i=1):
  - state=WAKE, clk_en_o=1, ready_o=0, sw_gate_ack_o=0.
  - idle_cnt=0, wake_cnt=0, gated_cycles_o=0.
  - Reset asserted mid-operation behaves identically; gated clock resumes on the next low phase.
- gate_cond = ~busy_i & ~wake_req_i & (auto_en_i | sw_gate_req_i).
- RUN:
  - If gate_cond, go to IDLE_WAIT and set idle_cnt=0.
- IDLE_WAIT (clock still enabled):
  - If ~gate_cond, go to RUN. This has priority.
  - Else if sw_gate_req_i, or idle_cnt == idle_thresh_i, go to GATED.
  - Else idle_cnt++.
  - idle_thresh_i=0 therefore gates one cycle after entering IDLE_WAIT.
  - idle_cnt never wraps: the equality exit fires first.
- GATED:
  - clk_en_o=0.
  - Exit to WAKE with wake_cnt=0 when any of: wake_req_i, busy_i, or (~auto_en_i & ~sw_gate_req_i).
- WAKE:
  - clk_en_o=1, wake_cnt++.
  - When wake_cnt == WAKE_CYCLES-1, go to RUN.
  - A gate request during WAKE is ignored until RUN.
- clk_en_o is a flop loaded with (next_state != GATED). The ICG latch samples it while clk_i is low, so gating takes effect on the clk_o pulse following the transition edge, and clk_o never glitches.
- ready_o is a flop loaded with (next_state is RUN or IDLE_WAIT).
  - Exit from reset: ready_o rises WAKE_CYCLES edges after rst_i deasserts.
- sw_gate_ack_o is a flop loaded with (next_state==GATED & sw_gate_req_i).
  - It drops the cycle after sw_gate_req_i falls.
  - If a wake cause forces exit while the request is held, ack drops and re-asserts only after re-entering GATED.
- gated_cycles_o increments each cycle state==GATED and saturates at all-ones.
- test_en_i ORs into the ICG enable only. The FSM, clk_en_o, ready_o and the counters are unaffected.
- Simultaneous busy_i and sw_gate_req_i: busy wins, no gating.

Decomposition:
- Shared package clk_gate_pkg holds:
  - state enum clk_gate_state_e (2 bits, encodings above);
  - constant CLK_GATE_WAKE_MAX=15.
- One sub-module: the behavioural ICG pulp_clock_gating2, instantiated with:
  - clk_i=clk_i;
  - en_i=clk_en_o;
  - test_en_i=test_en_i;
  - clk_o=clk_o.
- The FSM, counters and handshake stay in clk_gate_ctrl.

Test Plan:
- Reset exit: release rst_i, hold busy_i=1 -> state WAKE for 2 cycles, then RUN; ready_o=1 at the 2nd edge; clk_o toggles throughout.
- Auto gating: auto_en_i=1, idle_thresh_i=4, busy_i=0 -> IDLE_WAIT for 5 cycles, then GATED; clk_en_o=0; clk_o held low from the next low phase with no runt pulse.
- Hysteresis abort: idle_thresh_i=10, busy_i pulses high at idle cycle 6 -> return to RUN, clk_en_o never drops, gated_cycles_o=0.
- SW handshake: auto_en_i=0, sw_gate_req_i=1 -> GATED after 1 IDLE_WAIT cycle, sw_gate_ack_o=1; deassert req -> WAKE, ack=0 next cycle, RUN after 2 cycles.
- Wake/test: in GATED, assert wake_req_i -> WAKE next edge, clk_o resumes; separately, test_en_i=1 in GATED -> clk_o toggles while state_o stays 2.
- Saturation/reset mid-op: COUNT_W=4, remain gated 20 cycles -> gated_cycles_o=15; assert rst_i async mid-GATED -> outputs take reset values immediately.
